// File: rtl/w5300_common_regs_conf_seq_pkg.sv
// ----------------------------------------------------------------------------
// w5300_common_regs_conf_seq_pkg
//   Shared definitions for the W5300 common-register configuration sequencer:
//   LUT entry layout {op[26], addr[25:16], value[15:0]}, the terminator
//   address and the sequencer state encodings.
//   Optional macro: W5300_CONF_RETRY_EN adds the retry-gap state.
// ----------------------------------------------------------------------------
package w5300_common_regs_conf_seq_pkg;

    typedef struct packed {
        logic        op;      // 1 = write value, 0 = read and compare
        logic [9:0]  addr;
        logic [15:0] value;
    } conf_entry_t;

    localparam int          LUT_W     = $bits(conf_entry_t);
    localparam logic [9:0]  TERM_ADDR = 10'h3FF;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_NEXT  = 3'd4;
`ifdef W5300_CONF_RETRY_EN
    localparam logic [2:0] ST_GAP   = 3'd5;
`endif

    function automatic logic is_terminator(input conf_entry_t e);
        return e.addr == TERM_ADDR;
    endfunction

endpackage

// File: rtl/w5300_conf_wait_timer.sv
// ----------------------------------------------------------------------------
// w5300_conf_wait_timer
//   Loadable down-counter used by the configuration sequencer for both the
//   bus-ack timeout and the read-retry gap.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     load         load load_val (has priority over en)
//     load_val     value loaded; expired asserts load_val+1 enabled cycles later
//     en           count down by one (saturates at zero)
//     expired      count has reached zero
// ----------------------------------------------------------------------------
module w5300_conf_wait_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/w5300_common_regs_conf_seq.sv
// ----------------------------------------------------------------------------
// w5300_common_regs_conf_seq
//   Walks the W5300 common-register configuration LUT after a start pulse and
//   replays each entry as a host-bus transaction. Writes are fire-and-forget;
//   reads are compared against the entry value. Ends on the terminator
//   address, the last LUT entry, a compare mismatch or an ack timeout.
//   Optional macro: W5300_CONF_RETRY_EN -- a read mismatch idles the bus for
//   RETRY_GAP cycles and re-issues the entry, up to RETRY_MAX retries.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     start               begin at index 0 (ignored while busy)
//     busy/done/error     status; done/error are levels cleared by next start
//     err_index           LUT index of the failing entry
//     lut_index/lut_data  combinational LUT lookup
//     bus_req/bus_wr/bus_addr/bus_wdata   transaction request, held until ack
//     bus_ack/bus_rdata   one-cycle completion and read data
// ----------------------------------------------------------------------------
module w5300_common_regs_conf_seq
    import w5300_common_regs_conf_seq_pkg::*;
#(
    parameter int LUT_DEPTH   = 64,
    parameter int ACK_TIMEOUT = 1024
`ifdef W5300_CONF_RETRY_EN
    ,
    parameter int RETRY_MAX   = 8,
    parameter int RETRY_GAP   = 256
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [$clog2(LUT_DEPTH)-1:0] err_index,
    output logic [$clog2(LUT_DEPTH)-1:0] lut_index,
    input  logic [26:0]                  lut_data,
    output logic                         bus_req,
    output logic                         bus_wr,
    output logic [9:0]                   bus_addr,
    output logic [15:0]                  bus_wdata,
    input  logic                         bus_ack,
    input  logic [15:0]                  bus_rdata
);

    localparam int IW = $clog2(LUT_DEPTH);
`ifdef W5300_CONF_RETRY_EN
    localparam int TMAX = (ACK_TIMEOUT > RETRY_GAP) ? ACK_TIMEOUT : RETRY_GAP;
    localparam int RW   = $clog2(RETRY_MAX + 2);
`else
    localparam int TMAX = ACK_TIMEOUT;
`endif
    localparam int TW = $clog2(TMAX + 1);

    logic [2:0]    state;
    conf_entry_t   cur_entry;
    conf_entry_t   lut_entry;
    logic          read_miss;

    logic          tmr_load;
    logic          tmr_en;
    logic [TW-1:0] tmr_val;
    logic          tmr_expired;

`ifdef W5300_CONF_RETRY_EN
    logic [RW-1:0] retry_cnt;
    logic          retry_ok;
    assign retry_ok = (retry_cnt < RW'(RETRY_MAX));
`endif

    assign lut_entry = conf_entry_t'(lut_data);
    assign read_miss = !cur_entry.op && (bus_rdata != cur_entry.value);

    // One timer serves both waits: ack timeout is armed on issue, the retry
    // gap on a missed read, and the ack timeout again on re-issue.
    always_comb begin
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_ISSUE: begin
                tmr_load = 1'b1;
                tmr_val  = TW'(ACK_TIMEOUT - 1);
            end
            ST_WAIT: begin
                tmr_en = 1'b1;
`ifdef W5300_CONF_RETRY_EN
                if (bus_ack && read_miss && retry_ok) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(RETRY_GAP - 1);
                end
`endif
            end
`ifdef W5300_CONF_RETRY_EN
            ST_GAP: begin
                tmr_en = 1'b1;
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(ACK_TIMEOUT - 1);
                end
            end
`endif
            default: ;
        endcase
    end

    w5300_conf_wait_timer #(
        .WIDTH (TW)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cur_entry <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= '0;
            lut_index <= '0;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
`ifdef W5300_CONF_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_index <= '0;
                        lut_index <= '0;
                        state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    cur_entry <= lut_entry;
`ifdef W5300_CONF_RETRY_EN
                    retry_cnt <= '0;
`endif
                    if (is_terminator(lut_entry)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    bus_req   <= 1'b1;
                    bus_wr    <= cur_entry.op;
                    bus_addr  <= cur_entry.addr;
                    bus_wdata <= cur_entry.value;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!read_miss) begin
                            state <= ST_NEXT;
`ifdef W5300_CONF_RETRY_EN
                        end else if (retry_ok) begin
                            retry_cnt <= retry_cnt + RW'(1);
                            state     <= ST_GAP;
`endif
                        end else begin
                            busy      <= 1'b0;
                            error     <= 1'b1;
                            err_index <= lut_index;
                            state     <= ST_IDLE;
                        end
                    end else if (tmr_expired) begin
                        bus_req   <= 1'b0;
                        busy      <= 1'b0;
                        error     <= 1'b1;
                        err_index <= lut_index;
                        state     <= ST_IDLE;
                    end
                end
                ST_NEXT: begin
                    if (lut_index == IW'(LUT_DEPTH - 1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        lut_index <= lut_index + IW'(1);
                        state     <= ST_FETCH;
                    end
                end
`ifdef W5300_CONF_RETRY_EN
                // Entry is already registered, so re-issue goes straight to
                // WAIT and the bus stays idle for exactly RETRY_GAP cycles.
                ST_GAP: begin
                    if (tmr_expired) begin
                        bus_req <= 1'b1;
                        state   <= ST_WAIT;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
